fir3_top: RTL and testbench
===========================

Name: fir3_top

Overview:
- Three-tap direct-form FIR filter for a stream of signed 16-bit samples, one sample per clock.
- Computes y = h0·x[n] + h1·x[n-1] + h2·x[n-2] with runtime-programmable signed coefficients.
- Holds an internal delay line and a registered output.
- Top-level datapath block; the surrounding system drives samples and coefficients and consumes y.

Parameters:
- W, 32, output width in bits. Legal range is 32..48.
- XW, 16, sample width and coefficient width (signed). Fixed at 16 for this revision.

Ports:
- CLK  input  1  single clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- h0  input  16  signed coefficient for the newest tap.
- h1  input  16  signed coefficient for the middle tap.
- h2  input  16  signed coefficient for the oldest tap.
- x  input  16  signed input sample, captured every rising edge.
- y  output  W  signed filter output (registered).

Behaviour:
- Reset (rst=0): takes effect immediately, without waiting for a clock edge.
  - Tap registers d0, d1, d2 clear to 0.
  - y clears to 0.
  - State is held at 0 while rst is low; no samples are captured.
- Operation on each rising CLK edge with rst=1, all updates concurrent and using pre-edge register values:
  - d0 <= x
  - d1 <= d0
  - d2 <= d1
  - y <= h0·d0 + h1·d1 + h2·d2
- Latency: a sample captured at edge k appears as h0·x at y after edge k+1, as h1·x after edge k+2, and as h2·x after edge k+3.
- After the first edge following reset release, y is still 0, because the taps were 0.
- Coefficients:
  - Sampled combinationally at the edge; not registered.
  - Quasi-static. A change becomes effective for the y computed at the next edge.
  - No handshake or valid signal exists.
- Arithmetic:
  - All operands are two's-complement signed.
  - Each product is a full 32-bit signed value.
  - The sum is formed at 34 bits signed, so no internal overflow can occur.
  - Output mapping: if W ≤ 34, y = low W bits of the sum (wrap-around, no saturation). If W > 34, y = the sum sign-extended to W.
  - At W=32 the sum can wrap. Example: all coefficients = -32768 and x = -32768 gives y = -1073741824.
- Reset release mid-stream: the filter restarts from an all-zero history. No stale samples are reused.
- No X-propagation: every register has a defined reset value.

Test Plan:
- Reset: hold rst=0 with x=-1, h0=-3, h1=3, h2=5, then toggle CLK -> y=0 and taps stay 0. Assert rst=0 asynchronously between edges during activity -> y goes to 0 immediately.
- Directed sequence: release reset, h0=-3, h1=3, h2=5, drive x=-2, 3, 4 on successive edges, then hold x=4.
  - Outputs after edges 1..4: 0, 6, -15, -13.
  - Edge 5 (taps 4, 4, 3) gives -12+12+15 = 15.
- Impulse: h0=-3, h1=3, h2=5, x=1 for one edge then 0 -> y = -3, 3, 5, 0, 0 on the edges after capture.
- Longer stream: x = -5, 1, 0, 3, 4, 1, 2, 3, 4, 2, -1, 3, 2, 6, 1, -1, 7 with the same coefficients -> every y matches a reference model of -3·d0 + 3·d1 + 5·d2 computed from pre-edge taps.
- Overflow/wrap at W=32:
  - h0=h1=h2=-32768, x=-32768 held for 4 edges -> y settles to 0xC0000000 (-1073741824).
  - At W=40 the same stimulus -> y = +3221225472.
- Coefficient change mid-stream: x held at 2, h0 switched from 1 to 10 between edges -> the next y reflects 10·2 plus the older-tap terms, with no extra delay.

Source files
------------

// File: rtl/fir3_top.sv
// Three-tap direct-form FIR on signed samples with runtime coefficients.
// One sample per clock; y is registered, so h0*x appears one edge after x is captured.
module fir3_top #(
  parameter int W  = 32,
  parameter int XW = 16
) (
  input  logic          CLK,
  input  logic          rst,
  input  logic [XW-1:0] h0,
  input  logic [XW-1:0] h1,
  input  logic [XW-1:0] h2,
  input  logic [XW-1:0] x,
  output logic [W-1:0]  y
);

  localparam int PW = 2 * XW;
  localparam int SW = PW + 2;

  logic [XW-1:0] d0_q, d1_q, d2_q;
  logic [XW-1:0] d0_d, d1_d, d2_d;
  logic [W-1:0]  y_q, y_d;

  logic signed [PW-1:0] p0, p1, p2;
  logic signed [SW-1:0] sum;

  // Operands are sign-extended to full product width so the multiply is exact.
  assign p0 = $signed({{XW{h0[XW-1]}}, h0}) * $signed({{XW{d0_q[XW-1]}}, d0_q});
  assign p1 = $signed({{XW{h1[XW-1]}}, h1}) * $signed({{XW{d1_q[XW-1]}}, d1_q});
  assign p2 = $signed({{XW{h2[XW-1]}}, h2}) * $signed({{XW{d2_q[XW-1]}}, d2_q});

  assign sum = SW'(p0) + SW'(p1) + SW'(p2);

  // Narrower outputs wrap, wider ones sign-extend the exact sum.
  assign y_d  = W'(sum);
  assign d0_d = x;
  assign d1_d = d0_q;
  assign d2_d = d1_q;

  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) begin
      d0_q <= '0;
      d1_q <= '0;
      d2_q <= '0;
      y_q  <= '0;
    end else begin
      d0_q <= d0_d;
      d1_q <= d1_d;
      d2_q <= d2_d;
      y_q  <= y_d;
    end
  end

  assign y = y_q;

endmodule

// File: tb/tb_fir3_top.sv
// Randomized and directed bench for fir3_top at W=32 and W=40 against a sample-history model.
module tb_fir3_top;

  logic        CLK = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] h0 = '0, h1 = '0, h2 = '0, x = '0;
  logic [31:0] y32;
  logic [39:0] y40;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  // Model: list of samples captured since last reset, plus expected outputs.
  int     hist[$];
  longint exp_sum;
  logic [31:0] e32;
  logic [39:0] e40;

  fir3_top #(.W(32)) dut (
    .CLK(CLK), .rst(rst), .h0(h0), .h1(h1), .h2(h2), .x(x), .y(y32)
  );

  fir3_top #(.W(40)) dut40 (
    .CLK(CLK), .rst(rst), .h0(h0), .h1(h1), .h2(h2), .x(x), .y(y40)
  );

  always #5 CLK = ~CLK;

  function automatic longint model_sum();
    longint s;
    int n;
    n = hist.size();
    s = 0;
    if (n >= 1) s += longint'($signed(h0)) * longint'(hist[n-1]);
    if (n >= 2) s += longint'($signed(h1)) * longint'(hist[n-2]);
    if (n >= 3) s += longint'($signed(h2)) * longint'(hist[n-3]);
    return s;
  endfunction

  // Advance one rising edge, updating the model from the pre-edge history.
  task automatic tick();
    if (rst) begin
      exp_sum = model_sum();
      hist.push_back(int'($signed(x)));
      if (hist.size() > 3) void'(hist.pop_front());
    end
    e32 = 32'(exp_sum);
    e40 = 40'(exp_sum);
    @(posedge CLK);
    #1;
  endtask

  task automatic model_reset();
    hist.delete();
    exp_sum = 0;
    e32 = '0;
    e40 = '0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    x = 16'hFFFF; h0 = -16'sd3; h1 = 16'sd3; h2 = 16'sd5;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_cnt++;
      if (y32 !== 32'd0 || y40 !== 40'd0)
        $display("FAIL reset_hold edge %0d: y32=%0h y40=%0h required 0", i, y32, y40);
      else pass_cnt++;
    end
    rst = 1'b1;
    tick();
    chk_cnt++;
    if (y32 !== 32'd0) $display("FAIL reset_first_edge: y32=%0d required 0", $signed(y32));
    else pass_cnt++;
    rst = 1'b0;
    #1;
    model_reset();
  endtask

  task automatic test_directed();
    int xs[5]   = '{-2, 3, 4, 4, 4};
    int want[5] = '{0, 6, -15, -13, 15};
    rst = 1'b1;
    h0 = -16'sd3; h1 = 16'sd3; h2 = 16'sd5;
    for (int i = 0; i < 5; i++) begin
      x = 16'(xs[i]);
      tick();
      chk_cnt++;
      if ($signed(y32) !== want[i] || $signed(y40) !== 40'(want[i]))
        $display("FAIL directed edge %0d: y32=%0d y40=%0d required %0d",
                 i + 1, $signed(y32), $signed(y40), want[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_async_reset();
    #2 rst = 1'b0;
    #1;
    model_reset();
    chk_cnt++;
    if (y32 !== 32'd0 || y40 !== 40'd0)
      $display("FAIL async_reset: y32=%0d y40=%0d required 0", $signed(y32), $signed(y40));
    else pass_cnt++;
    #1 rst = 1'b1;
    x = 16'sd7;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_cnt++;
      if (y32 !== e32 || y40 !== e40)
        $display("FAIL restart edge %0d: y32=%0d required %0d", i, $signed(y32), $signed(e32));
      else pass_cnt++;
    end
  endtask

  task automatic pulse_reset();
    rst = 1'b0;
    #1;
    model_reset();
    rst = 1'b1;
  endtask

  task automatic test_impulse();
    int want[6] = '{0, -3, 3, 5, 0, 0};
    pulse_reset();
    h0 = -16'sd3; h1 = 16'sd3; h2 = 16'sd5;
    for (int i = 0; i < 6; i++) begin
      x = (i == 0) ? 16'sd1 : 16'sd0;
      tick();
      chk_cnt++;
      if ($signed(y32) !== want[i] || y32 !== e32)
        $display("FAIL impulse edge %0d: y32=%0d required %0d", i, $signed(y32), want[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_stream();
    int xs[17] = '{-5, 1, 0, 3, 4, 1, 2, 3, 4, 2, -1, 3, 2, 6, 1, -1, 7};
    h0 = -16'sd3; h1 = 16'sd3; h2 = 16'sd5;
    for (int i = 0; i < 17; i++) begin
      x = 16'(xs[i]);
      tick();
      chk_cnt++;
      if (y32 !== e32 || y40 !== e40)
        $display("FAIL stream edge %0d: y32=%0d y40=%0d required %0d",
                 i, $signed(y32), $signed(y40), exp_sum);
      else pass_cnt++;
    end
  endtask

  task automatic test_wrap();
    pulse_reset();
    h0 = 16'h8000; h1 = 16'h8000; h2 = 16'h8000; x = 16'h8000;
    for (int i = 0; i < 4; i++) tick();
    chk_cnt++;
    if (y32 !== 32'hC000_0000 || y32 !== e32)
      $display("FAIL wrap_w32: y32=%0h required c0000000", y32);
    else pass_cnt++;
    chk_cnt++;
    if (y40 !== 40'd3221225472 || y40 !== e40)
      $display("FAIL wide_w40: y40=%0d required 3221225472", y40);
    else pass_cnt++;
  endtask

  task automatic test_coef_change();
    pulse_reset();
    h0 = 16'sd1; h1 = 16'sd3; h2 = 16'sd5; x = 16'sd2;
    for (int i = 0; i < 4; i++) tick();
    chk_cnt++;
    if ($signed(y32) !== 18) $display("FAIL coef_before: y32=%0d required 18", $signed(y32));
    else pass_cnt++;
    h0 = 16'sd10;
    tick();
    chk_cnt++;
    if ($signed(y32) !== 36 || y32 !== e32)
      $display("FAIL coef_after: y32=%0d required 36", $signed(y32));
    else pass_cnt++;
  endtask

  task automatic test_random();
    pulse_reset();
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 19) == 0 || i == 0) begin
        h0 = 16'($urandom); h1 = 16'($urandom); h2 = 16'($urandom);
      end
      if ($urandom_range(0, 39) == 0) begin
        #2 rst = 1'b0;
        #1;
        model_reset();
        chk_cnt++;
        if (y32 !== 32'd0 || y40 !== 40'd0)
          $display("FAIL random_async_reset iter %0d: y32=%0h y40=%0h required 0", i, y32, y40);
        else pass_cnt++;
        #1 rst = 1'b1;
      end
      x = ($urandom_range(0, 7) == 0) ? 16'h8000 : 16'($urandom);
      tick();
      chk_cnt++;
      if (y32 !== e32 || y40 !== e40)
        $display("FAIL random iter %0d: y32=%0h y40=%0h required %0h/%0h",
                 i, y32, y40, e32, e40);
      else pass_cnt++;
    end
  endtask

  initial begin
    model_reset();
    #1;
    test_reset();
    test_directed();
    test_async_reset();
    test_impulse();
    test_stream();
    test_wrap();
    test_coef_change();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
